pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_ctrl_pkg.sv | 22 ++
 rtl/sync_bit.sv | 32 +++
 rtl/pll_reset_sequencer.sv | 131 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding and default timing constants for the PLL reset sequencer.
package pll_ctrl_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_t;

  localparam int DEF_SYNC_STAGES         = 2;
  localparam int DEF_PLL_RESET_CYCLES    = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level signal.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (srst) sync_reg[0] <= 1'b0;
          else      sync_reg[0] <= d;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (srst) sync_reg[gi] <= 1'b0;
          else      sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the PLL in reset, waits for a stable lock, then releases downstream reset;
// re-sequences on lock loss, lock timeout or an explicit relock request.
module pll_reset_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int PLL_RESET_CYCLES    = DEF_PLL_RESET_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       locked,
  output logic [7:0] loss_count,
  output logic [7:0] timeout_count
);

  localparam int CNT_MAX = max3(PLL_RESET_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  pll_state_t       state_reg;
  logic [CNT_W-1:0] count_reg;
  logic             pll_reset_reg;
  logic             sys_reset_reg;
  logic             locked_reg;
  logic [7:0]       loss_reg;
  logic [7:0]       timeout_reg;
  logic             lock_s;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk  (refclk),
    .srst (reset),
    .d    (pll_lock),
    .q    (lock_s)
  );

  always_ff @(posedge refclk) begin
    if (reset) begin
      state_reg     <= RESET_PLL;
      count_reg     <= '0;
      pll_reset_reg <= 1'b1;
      sys_reset_reg <= 1'b1;
      locked_reg    <= 1'b0;
      loss_reg      <= '0;
      timeout_reg   <= '0;
    end else begin
      case (state_reg)
        RESET_PLL: begin
          if (count_reg == RESET_LAST) begin
            state_reg     <= WAIT_LOCK;
            count_reg     <= '0;
            pll_reset_reg <= 1'b0;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end

        WAIT_LOCK: begin
          if (relock_req || (!lock_s && count_reg == TIMEOUT_LAST)) begin
            if (!relock_req && timeout_reg != 8'hFF)
              timeout_reg <= timeout_reg + 8'd1;
            state_reg     <= RESET_PLL;
            count_reg     <= '0;
            pll_reset_reg <= 1'b1;
          end else if (lock_s) begin
            state_reg <= STABLE;
            count_reg <= '0;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end

        STABLE: begin
          if (relock_req) begin
            state_reg     <= RESET_PLL;
            count_reg     <= '0;
            pll_reset_reg <= 1'b1;
          end else if (!lock_s) begin
            // A dropout here is a settling glitch, not a loss: restart the wait quietly.
            state_reg <= WAIT_LOCK;
            count_reg <= '0;
          end else if (count_reg == STABLE_LAST) begin
            state_reg     <= RUN;
            count_reg     <= '0;
            sys_reset_reg <= 1'b0;
            locked_reg    <= 1'b1;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end

        RUN: begin
          if (!lock_s && loss_reg != 8'hFF)
            loss_reg <= loss_reg + 8'd1;
          if (!lock_s || relock_req) begin
            state_reg     <= RESET_PLL;
            count_reg     <= '0;
            pll_reset_reg <= 1'b1;
            sys_reset_reg <= 1'b1;
            locked_reg    <= 1'b0;
          end
        end

        default: begin
          state_reg     <= RESET_PLL;
          count_reg     <= '0;
          pll_reset_reg <= 1'b1;
          sys_reset_reg <= 1'b1;
          locked_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign pll_reset     = pll_reset_reg;
  assign sys_reset     = sys_reset_reg;
  assign locked        = locked_reg;
  assign loss_count    = loss_reg;
  assign timeout_count = timeout_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues each expected output change with its cycle,
// a monitor pops and compares whenever the DUT outputs change.
module tb_pll_reset_sequencer;

  logic       refclk;
  logic       reset;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_reset;
  logic       sys_reset;
  logic       locked;
  logic [7:0] loss_count;
  logic [7:0] timeout_count;

  typedef struct {
    int         cyc;
    logic       pr;
    logic       sr;
    logic       lk;
    logic [7:0] lc;
    logic [7:0] tc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES         (2),
    .PLL_RESET_CYCLES    (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32)
  ) dut (
    .refclk        (refclk),
    .reset         (reset),
    .pll_lock      (pll_lock),
    .relock_req    (relock_req),
    .pll_reset     (pll_reset),
    .sys_reset     (sys_reset),
    .locked        (locked),
    .loss_count    (loss_count),
    .timeout_count (timeout_count)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  // Cycle 0 is the first cycle with reset low after the last reset edge.
  always @(posedge refclk) cyc <= reset ? 0 : cyc + 1;

  task automatic push(input int c, input logic pr, input logic sr, input logic lk,
                      input logic [7:0] lc, input logic [7:0] tc);
    exp_t e;
    e.cyc = c; e.pr = pr; e.sr = sr; e.lk = lk; e.lc = lc; e.tc = tc;
    exp_q.push_back(e);
  endtask

  task automatic go_to(input int t);
    int guard;
    guard = 0;
    while (cyc != t && guard < 20000) begin
      @(negedge refclk);
      guard++;
    end
    if (cyc != t) begin
      checks++;
      errors++;
      $display("FAIL wait_cycle got=%0d required=%0d", cyc, t);
    end
  endtask

  // Monitor: every change on the output bundle is one transaction.
  initial begin
    logic [18:0] prev_v;
    logic [18:0] cur_v;
    logic [18:0] exp_v;
    exp_t        e;
    prev_v = 'x;
    forever begin
      @(negedge refclk);
      cur_v = {pll_reset, sys_reset, locked, loss_count, timeout_count};
      if (cur_v !== prev_v) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got pr=%b sr=%b lk=%b loss=%0d to=%0d",
                   cyc, pll_reset, sys_reset, locked, loss_count, timeout_count);
        end else begin
          e = exp_q.pop_front();
          exp_v = {e.pr, e.sr, e.lk, e.lc, e.tc};
          if (cur_v !== exp_v || e.cyc != cyc) begin
            errors++;
            $display("FAIL out_change got cyc=%0d pr=%b sr=%b lk=%b loss=%0d to=%0d required cyc=%0d pr=%b sr=%b lk=%b loss=%0d to=%0d",
                     cyc, pll_reset, sys_reset, locked, loss_count, timeout_count,
                     e.cyc, e.pr, e.sr, e.lk, e.lc, e.tc);
          end else begin
            $display("ok cyc=%0d pr=%b sr=%b lk=%b loss=%0d to=%0d",
                     cyc, pll_reset, sys_reset, locked, loss_count, timeout_count);
          end
        end
      end
      prev_v = cur_v;
    end
  end

  initial begin
    logic [7:0] loss_exp;
    int         c;

    // Clean start
    reset = 1'b1; pll_lock = 1'b1; relock_req = 1'b0;
    push(0, 1, 1, 0, 0, 0);
    repeat (3) @(negedge refclk);
    reset = 1'b0;
    push(4,  0, 1, 0, 0, 0);
    push(13, 0, 0, 1, 0, 0);

    // Relock from RUN, then a 3-cycle glitch at STABLE count 5
    go_to(20);
    relock_req = 1'b1;
    push(21, 1, 1, 0, 0, 0);
    push(25, 0, 1, 0, 0, 0);
    push(45, 0, 0, 1, 0, 0);
    go_to(21); relock_req = 1'b0;
    go_to(31); pll_lock = 1'b0;
    go_to(34); pll_lock = 1'b1;

    // Lock loss in RUN followed by three WAIT_LOCK timeouts
    go_to(50);
    pll_lock = 1'b0;
    push(53,  1, 1, 0, 1, 0);
    push(57,  0, 1, 0, 1, 0);
    push(89,  1, 1, 0, 1, 1);
    push(93,  0, 1, 0, 1, 1);
    push(125, 1, 1, 0, 1, 2);
    push(129, 0, 1, 0, 1, 2);
    push(161, 1, 1, 0, 1, 3);
    push(165, 0, 1, 0, 1, 3);
    push(177, 0, 0, 1, 1, 3);
    go_to(166); pll_lock = 1'b1;

    // Relock and lock loss in the same RUN cycle; relock during RESET_PLL ignored
    go_to(185);
    pll_lock = 1'b0;
    push(188, 1, 1, 0, 2, 3);
    push(192, 0, 1, 0, 2, 3);
    push(201, 0, 0, 1, 2, 3);
    go_to(187); relock_req = 1'b1;
    go_to(188); relock_req = 1'b0; pll_lock = 1'b1;
    go_to(189); relock_req = 1'b1;
    go_to(190); relock_req = 1'b0;

    // 300 lock losses drive loss_count into saturation
    loss_exp = 8'd2;
    for (int i = 0; i < 300; i++) begin
      c = 205 + 17 * i;
      go_to(c);
      pll_lock = 1'b0;
      loss_exp = (loss_exp == 8'hFF) ? 8'hFF : loss_exp + 8'd1;
      push(c + 3,  1, 1, 0, loss_exp, 3);
      push(c + 7,  0, 1, 0, loss_exp, 3);
      push(c + 16, 0, 0, 1, loss_exp, 3);
      go_to(c + 3);
      pll_lock = 1'b1;
    end

    // Reset asserted in RUN restarts the whole sequence
    go_to(5310);
    push(0, 1, 1, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(negedge refclk);
    reset = 1'b0;
    push(4,  0, 1, 0, 0, 0);
    push(13, 0, 0, 1, 0, 0);
    go_to(20);
    repeat (5) @(negedge refclk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
